// File: rtl/operand_encoder.sv
// x86 ModRM/SIB/displacement/immediate byte-stream encoder.
// Optional disp8 compression is enabled by defining OPERAND_ENCODER_DISP8_EN.
module operand_encoder #(
    parameter int unsigned IMM_MAX_BYTES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_rm_is_mem,
    input  logic [3:0]  in_base,
    input  logic        in_has_base,
    input  logic [3:0]  in_index,
    input  logic        in_has_index,
    input  logic [1:0]  in_scale_log2,
    input  logic        in_rip_rel,
    input  logic [31:0] in_disp,
    input  logic [3:0]  in_reg,
    input  logic [3:0]  in_imm_size,
    input  logic [63:0] in_imm,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [2:0]  rex_rxb,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, MODRM, SIB, DISP, IMM} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  rex_q, rex_d;
    logic        err_q, err_d;

    logic        mem_q, has_base_q, has_index_q, rip_q;
    logic [3:0]  base_q, index_q, reg_q, imm_size_q;
    logic [1:0]  scale_q;
    logic [31:0] disp_q;
    logic [63:0] imm_q;

    logic        accept, illegal, size_ok;
    logic        need_sib;
    logic [1:0]  mod_v;
    logic [2:0]  rm_v;
    logic [3:0]  disp_len;
    logic [7:0]  modrm_byte, sib_byte;
    state_t      after_modrm, after_sib, after_disp, nxt;
    logic        stay;

    assign accept  = in_valid && in_ready;
    assign size_ok = (in_imm_size == 4'd0) || (in_imm_size == 4'd1) || (in_imm_size == 4'd2) ||
                     (in_imm_size == 4'd4) || (in_imm_size == 4'd8);
    assign illegal = (in_has_index && (in_index == 4'b0100)) || !size_ok ||
                     (32'(in_imm_size) > IMM_MAX_BYTES) || (in_rip_rel && !in_rm_is_mem);

    // Addressing-form decode works entirely from the latched descriptor.
    always_comb begin
        need_sib = 1'b0;
        mod_v    = 2'b11;
        rm_v     = base_q[2:0];
        disp_len = 4'd0;
        if (mem_q) begin
            if (rip_q) begin
                mod_v    = 2'b00;
                rm_v     = 3'b101;
                disp_len = 4'd4;
            end else begin
                need_sib = has_index_q || !has_base_q || (base_q[2:0] == 3'b100);
                rm_v     = need_sib ? 3'b100 : base_q[2:0];
                if (!has_base_q) begin
                    mod_v    = 2'b00;
                    disp_len = 4'd4;
                end else if ((disp_q == '0) && (base_q[2:0] != 3'b101)) begin
                    mod_v    = 2'b00;
                    disp_len = 4'd0;
`ifdef OPERAND_ENCODER_DISP8_EN
                end else if ((&disp_q[31:7]) || !(|disp_q[31:7])) begin
                    mod_v    = 2'b01;
                    disp_len = 4'd1;
`endif
                end else begin
                    mod_v    = 2'b10;
                    disp_len = 4'd4;
                end
            end
        end
    end

    assign modrm_byte  = {mod_v, reg_q[2:0], rm_v};
    assign sib_byte    = {scale_q, has_index_q ? index_q[2:0] : 3'b100,
                          has_base_q ? base_q[2:0] : 3'b101};
    assign after_disp  = (imm_size_q != 4'd0) ? IMM : IDLE;
    assign after_sib   = (disp_len != 4'd0) ? DISP : after_disp;
    assign after_modrm = need_sib ? SIB : after_sib;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rex_d     = rex_q;
        err_d     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_byte  = '0;
        out_last  = 1'b0;
        nxt       = IDLE;
        stay      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = MODRM;
                        cnt_d   = '0;
                        rex_d   = {in_reg[3], in_index[3] & in_has_index, in_base[3]};
                    end
                end
            end
            MODRM: begin
                out_valid = 1'b1;
                out_byte  = modrm_byte;
                nxt       = after_modrm;
            end
            SIB: begin
                out_valid = 1'b1;
                out_byte  = sib_byte;
                nxt       = after_sib;
            end
            DISP: begin
                out_valid = 1'b1;
                out_byte  = 8'(disp_q >> {cnt_q[1:0], 3'b000});
                stay      = (cnt_q != disp_len - 4'd1);
                nxt       = stay ? DISP : after_disp;
            end
            IMM: begin
                out_valid = 1'b1;
                out_byte  = 8'(imm_q >> {cnt_q[2:0], 3'b000});
                stay      = (cnt_q != imm_size_q - 4'd1);
                nxt       = stay ? IMM : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (out_valid) begin
            out_last = (nxt == IDLE);
            if (out_ready) begin
                state_d = nxt;
                cnt_d   = stay ? cnt_q + 4'd1 : '0;
                if (nxt == IDLE) begin
                    rex_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rex_q       <= '0;
            err_q       <= 1'b0;
            mem_q       <= 1'b0;
            has_base_q  <= 1'b0;
            has_index_q <= 1'b0;
            rip_q       <= 1'b0;
            base_q      <= '0;
            index_q     <= '0;
            reg_q       <= '0;
            imm_size_q  <= '0;
            scale_q     <= '0;
            disp_q      <= '0;
            imm_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rex_q   <= rex_d;
            err_q   <= err_d;
            if (accept) begin
                mem_q       <= in_rm_is_mem;
                has_base_q  <= in_has_base;
                has_index_q <= in_has_index;
                rip_q       <= in_rip_rel;
                base_q      <= in_base;
                index_q     <= in_index;
                reg_q       <= in_reg;
                imm_size_q  <= in_imm_size;
                scale_q     <= in_scale_log2;
                disp_q      <= in_disp;
                imm_q       <= in_imm;
            end
        end
    end

    assign rex_rxb = rex_q;
    assign err     = err_q;

endmodule

// File: tb/tb_operand_encoder.sv
// Bench for operand_encoder: directed descriptors against a spec-level byte model.
module tb_operand_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_rm_is_mem = 1'b0;
    logic [3:0]  in_base = '0;
    logic        in_has_base = 1'b0;
    logic [3:0]  in_index = '0;
    logic        in_has_index = 1'b0;
    logic [1:0]  in_scale_log2 = '0;
    logic        in_rip_rel = 1'b0;
    logic [31:0] in_disp = '0;
    logic [3:0]  in_reg = '0;
    logic [3:0]  in_imm_size = '0;
    logic [63:0] in_imm = '0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [2:0]  rex_rxb;
    logic        err;

    always #5 clk = ~clk;

    operand_encoder #(.IMM_MAX_BYTES(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rm_is_mem(in_rm_is_mem), .in_base(in_base), .in_has_base(in_has_base),
        .in_index(in_index), .in_has_index(in_has_index), .in_scale_log2(in_scale_log2),
        .in_rip_rel(in_rip_rel), .in_disp(in_disp), .in_reg(in_reg),
        .in_imm_size(in_imm_size), .in_imm(in_imm), .out_byte(out_byte),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .rex_rxb(rex_rxb), .err(err)
    );

    typedef struct packed {
        logic        mem;
        logic        rip;
        logic [3:0]  base;
        logic        hb;
        logic [3:0]  idx;
        logic        hi;
        logic [1:0]  sc;
        logic [31:0] disp;
        logic [3:0]  rg;
        logic [3:0]  isz;
        logic [63:0] imm;
    } desc_t;

    typedef logic [7:0] bq_t[$];

    int   checks = 0;
    int   passes = 0;
    bq_t  exp_q;
    bq_t  got_q;
    logic [2:0] exp_rex = '0;
    logic stall_prev = 1'b0;
    logic [7:0] byte_prev = '0;
    logic last_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic desc_t mk(input logic mem, input logic rip, input logic [3:0] base,
                                 input logic hb, input logic [3:0] idx, input logic hi,
                                 input logic [1:0] sc, input logic [31:0] disp,
                                 input logic [3:0] rg, input logic [3:0] isz,
                                 input logic [63:0] imm);
        desc_t d;
        d.mem = mem; d.rip = rip; d.base = base; d.hb = hb; d.idx = idx; d.hi = hi;
        d.sc = sc; d.disp = disp; d.rg = rg; d.isz = isz; d.imm = imm;
        return d;
    endfunction

    // Expected byte stream derived directly from the addressing-mode rules.
    function automatic bq_t model(input desc_t d);
        bq_t q;
        int unsigned mod_f, rm_f, dlen;
        bit sib;
        int sd;
        sd = $signed(d.disp);
        sib = 0;
        dlen = 0;
        if (!d.mem) begin
            mod_f = 3; rm_f = d.base % 8;
        end else if (d.rip) begin
            mod_f = 0; rm_f = 5; dlen = 4;
        end else begin
            sib  = d.hi || !d.hb || (d.base % 8 == 4);
            rm_f = sib ? 4 : d.base % 8;
            if (!d.hb) begin
                mod_f = 0; dlen = 4;
            end else if (sd == 0 && d.base % 8 != 5) begin
                mod_f = 0;
`ifdef OPERAND_ENCODER_DISP8_EN
            end else if (sd >= -128 && sd <= 127) begin
                mod_f = 1; dlen = 1;
`endif
            end else begin
                mod_f = 2; dlen = 4;
            end
        end
        q.push_back(8'(mod_f * 64 + (d.rg % 8) * 8 + rm_f));
        if (sib) q.push_back(8'(d.sc * 64 + (d.hi ? d.idx % 8 : 4) * 8 + (d.hb ? d.base % 8 : 5)));
        for (int i = 0; i < int'(dlen); i++) q.push_back(8'(d.disp >> (8 * i)));
        for (int i = 0; i < int'(d.isz); i++) q.push_back(8'(d.imm >> (8 * i)));
        return q;
    endfunction

    // Single compare process: every valid output cycle is checked against the model.
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_byte: got %0h expected no output", out_byte);
            end else begin
                chk("stream_byte", out_byte, exp_q[0]);
                chk("stream_last", out_last, exp_q.size() == 1);
                chk("stream_rex", rex_rxb, exp_rex);
            end
            if (stall_prev) begin
                chk("hold_byte", out_byte, byte_prev);
                chk("hold_last", out_last, last_prev);
            end
            if (out_ready) begin
                got_q.push_back(out_byte);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                byte_prev  = out_byte;
                last_prev  = out_last;
            end
        end else begin
            if (stall_prev) chk("hold_valid", out_valid, 1'b1);
            stall_prev = 1'b0;
        end
    end

    task automatic drive(input desc_t d);
        in_rm_is_mem = d.mem; in_rip_rel = d.rip; in_base = d.base; in_has_base = d.hb;
        in_index = d.idx; in_has_index = d.hi; in_scale_log2 = d.sc; in_disp = d.disp;
        in_reg = d.rg; in_imm_size = d.isz; in_imm = d.imm;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic start(input desc_t d, input bq_t lit, input string name, input bit toggle);
        bq_t m;
        m = model(d);
        chk({name, "_model_len"}, m.size(), lit.size());
        for (int i = 0; i < m.size() && i < lit.size(); i++) chk({name, "_model_byte"}, m[i], lit[i]);
        got_q.delete();
        exp_q   = m;
        exp_rex = {d.rg[3], d.idx[3] & d.hi, d.base[3]};
        @(negedge clk);
        chk({name, "_in_ready"}, in_ready, 1'b1);
        drive(d);
        out_ready = toggle ? 1'b0 : 1'b1;
    endtask

    task automatic run(input desc_t d, input bq_t lit, input string name, input bit toggle);
        int cyc;
        start(d, lit, name, toggle);
        cyc = 0;
        while (got_q.size() < lit.size() && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
            if (toggle) out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        chk({name, "_count"}, got_q.size(), lit.size());
        for (int i = 0; i < got_q.size() && i < lit.size(); i++) chk({name, "_dut_byte"}, got_q[i], lit[i]);
        chk({name, "_ready_after"}, in_ready, 1'b1);
        chk({name, "_idle_after"}, out_valid, 1'b0);
    endtask

    task automatic illegal(input desc_t d, input string name);
        @(negedge clk);
        chk({name, "_in_ready"}, in_ready, 1'b1);
        drive(d);
        chk({name, "_err_pulse"}, err, 1'b1);
        chk({name, "_no_valid"}, out_valid, 1'b0);
        chk({name, "_still_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk({name, "_err_clear"}, err, 1'b0);
        chk({name, "_no_valid2"}, out_valid, 1'b0);
    endtask

    desc_t d_rip;
    bq_t   lit;
    int    cyc;

    initial begin
        #2;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_last", out_last, 1'b0);
        chk("reset_byte", out_byte, 8'h00);
        chk("reset_rex", rex_rxb, 3'b000);
        chk("reset_err", err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("post_reset_ready", in_ready, 1'b1);

        lit = '{8'hD9};
        run(mk(0, 0, 4'b1001, 1, 4'd0, 0, 2'd0, 32'd0, 4'b0011, 4'd0, 64'd0), lit, "reg_rm", 0);

`ifdef OPERAND_ENCODER_DISP8_EN
        lit = '{8'h45, 8'h00};
`else
        lit = '{8'h85, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        run(mk(1, 0, 4'b0101, 1, 4'd0, 0, 2'd0, 32'd0, 4'b0000, 4'd0, 64'd0), lit, "base101_disp0", 0);

`ifdef OPERAND_ENCODER_DISP8_EN
        lit = '{8'h54, 8'h88, 8'h10};
`else
        lit = '{8'h94, 8'h88, 8'h10, 8'h00, 8'h00, 8'h00};
`endif
        run(mk(1, 0, 4'b0000, 1, 4'b0001, 1, 2'd2, 32'h10, 4'b0010, 4'd0, 64'd0), lit, "sib_index", 0);

        d_rip = mk(1, 1, 4'd0, 0, 4'd0, 0, 2'd0, 32'h12345678, 4'd0, 4'd4, 64'hAABBCCDD);
        lit = '{8'h05, 8'h78, 8'h56, 8'h34, 8'h12, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        run(d_rip, lit, "rip_stall", 1);

        lit = '{8'h3C, 8'hDD, 8'hFC, 8'hFF, 8'hFF, 8'hFF};
        run(mk(1, 0, 4'd0, 0, 4'b0011, 1, 2'd3, 32'hFFFFFFFC, 4'b0111, 4'd0, 64'd0), lit, "no_base", 0);

        lit = '{8'h8C, 8'h24, 8'h80, 8'h00, 8'h00, 8'h00, 8'h5A};
        run(mk(1, 0, 4'b0100, 1, 4'd0, 0, 2'd0, 32'h80, 4'b0001, 4'd1, 64'h5A), lit, "rsp_disp128", 1);

`ifdef OPERAND_ENCODER_DISP8_EN
        lit = '{8'h43, 8'h80, 8'h34, 8'h12};
`else
        lit = '{8'h83, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h34, 8'h12};
`endif
        run(mk(1, 0, 4'b0011, 1, 4'd0, 0, 2'd0, 32'hFFFFFF80, 4'b0000, 4'd2, 64'h1234), lit, "disp_m128", 0);

        lit = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run(mk(0, 0, 4'd0, 0, 4'd0, 0, 2'd0, 32'd0, 4'd0, 4'd8, 64'h0807060504030201), lit, "imm8", 0);

        illegal(mk(1, 0, 4'd1, 1, 4'b0100, 1, 2'd0, 32'd0, 4'd0, 4'd0, 64'd0), "ill_index4");
        illegal(mk(0, 0, 4'd1, 0, 4'd0, 0, 2'd0, 32'd0, 4'd0, 4'd3, 64'd0), "ill_imm3");
        illegal(mk(0, 1, 4'd1, 0, 4'd0, 0, 2'd0, 32'd0, 4'd0, 4'd0, 64'd0), "ill_rip_reg");

        lit = '{8'h05, 8'h78, 8'h56, 8'h34, 8'h12, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        start(d_rip, lit, "rip_reset", 1);
        cyc = 0;
        while (got_q.size() < 2 && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
            out_ready = ~out_ready;
        end
        chk("rip_reset_two_bytes", got_q.size(), 2);
        reset = 1'b0;
        #1;
        chk("mid_reset_valid", out_valid, 1'b0);
        chk("mid_reset_last", out_last, 1'b0);
        chk("mid_reset_rex", rex_rxb, 3'b000);
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

`ifdef OPERAND_ENCODER_DISP8_EN
        lit = '{8'h54, 8'h88, 8'h10};
`else
        lit = '{8'h94, 8'h88, 8'h10, 8'h00, 8'h00, 8'h00};
`endif
        run(mk(1, 0, 4'b0000, 1, 4'b0001, 1, 2'd2, 32'h10, 4'b0010, 4'd0, 64'd0), lit, "after_reset", 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/operand_encoder.md
OPERAND_ENCODER -- requirements
Module: operand_encoder

Interface
REQ-001 SHALL have parameter IMM_MAX_BYTES, default 8, the largest immediate size accepted (legal values 4 or 8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand descriptor is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the encoder accepts a descriptor.
REQ-006 SHALL have port in_rm_is_mem, input, 1 bit: 1 = ModRM.rm names memory, 0 = register.
REQ-007 SHALL have ports in_base (input, 4 bits: base/rm register id) and in_has_base (input, 1 bit).
REQ-008 SHALL have ports in_index (input, 4 bits), in_has_index (input, 1 bit) and in_scale_log2 (input, 2 bits).
REQ-009 SHALL have ports in_rip_rel (input, 1 bit) and in_disp (input, 32 bits, signed displacement).
REQ-010 SHALL have port in_reg, input, 4 bits: the ModRM.reg register id or group extension.
REQ-011 SHALL have ports in_imm_size (input, 4 bits, value 0/1/2/4/8 bytes) and in_imm (input, 64 bits).
REQ-012 SHALL have ports out_byte (output, 8 bits), out_valid (output, 1 bit), out_ready (input, 1 bit) and out_last (output, 1 bit) forming the byte stream.
REQ-013 SHALL have port rex_rxb, output, 3 bits: {R,X,B} = {in_reg[3], in_index[3]&has_index, base[3]}; held from the accept cycle until the last byte is accepted.
REQ-014 SHALL have port err, output, 1 bit: a one-cycle pulse when an illegal descriptor is accepted.

Function
REQ-015 SHALL implement the states IDLE, MODRM, SIB, DISP and IMM; in_ready = 1 only in IDLE.
REQ-016 SHALL latch all in_* fields on in_valid&in_ready, and SHALL present the first byte (ModRM) on the next cycle.
REQ-017 SHALL, for a register rm, emit mod=11, rm=base[2:0], with no SIB and no displacement.
REQ-018 SHALL, for in_rip_rel, emit mod=00, rm=101, followed by disp32; base and index are ignored.
REQ-019 SHALL need a SIB byte when has_index, or when !has_base, or when base[2:0]=100; in that case rm=100 and SIB={scale_log2, has_index?index[2:0]:100, has_base?base[2:0]:101}.
REQ-020 SHALL select mod as follows: no base gives mod 00 with disp32; a base with disp==0 and base[2:0]!=101 gives mod 00; a disp fitting in int8 gives mod 01 with disp8 (this also covers base[2:0]=101 with disp 0); anything else gives mod 10 with disp32.
REQ-021 SHALL emit the displacement and then the immediate, each little-endian, with one byte per out_valid&out_ready handshake.
REQ-022 SHALL hold out_byte and out_last stable while out_valid&!out_ready.
REQ-023 SHALL assert out_last only on the final byte, and SHALL return to IDLE on the cycle that byte is accepted (in_ready=1 on the next cycle).
REQ-024 SHALL treat the following as illegal: has_index with index=0100; in_imm_size not in {0,1,2,4,8}; in_imm_size>IMM_MAX_BYTES; in_rip_rel with !in_rm_is_mem.
REQ-025 SHALL, on an illegal descriptor, pulse err for one cycle, emit no bytes and remain in IDLE.
REQ-026 SHALL use a 4-bit byte counter within the DISP and IMM states, which resets to 0 on each state entry.

Reset
REQ-027 SHALL, on asserted reset (at any time, including mid-stream), force the state to IDLE and set out_valid=0, out_last=0, out_byte=0, rex_rxb=0, err=0 and the counter to 0.
REQ-028 SHALL drive in_ready=1 from the first cycle after reset is deasserted; any partially sent stream is discarded.

Configuration
REQ-029 SHALL, when OPERAND_ENCODER_DISP8_EN is defined, apply the disp8 compression of REQ-020.
REQ-030 SHALL, when OPERAND_ENCODER_DISP8_EN is undefined, use mod 10 with disp32 for every based memory operand except the mod-00 case, including base[2:0]=101 with disp 0.

Verification
REQ-031 SHALL cover: register rm, base=1001, reg=0011, imm_size=0 -> single byte D9 with out_last=1 and rex_rxb=001.
REQ-032 SHALL cover: memory [base=0101] with disp 0 and reg=000 -> with DISP8_EN the bytes 45 00; without it the bytes 85 00 00 00 00.
REQ-033 SHALL cover: base=0000, index=0001, scale_log2=2, disp=0x10, reg=010 -> with DISP8_EN the bytes 54 88 10; without it the bytes 94 88 10 00 00 00.
REQ-034 SHALL cover: rip_rel with disp=0x12345678, imm_size=4, imm=0xAABBCCDD and out_ready toggling every other cycle -> bytes 05 78 56 34 12 DD CC BB AA, each byte held while stalled, out_last only on AA.
REQ-035 SHALL cover: has_index with index=0100 -> err pulses for one cycle, no out_valid, in_ready stays 1; then imm_size=3 -> err again.
REQ-036 SHALL cover: reset asserted after the 2nd byte of the REQ-034 stream -> out_valid=0 immediately; after release, a new descriptor encodes correctly starting from its ModRM byte.
